// File: rtl/chan_512_start_ctrl.sv
// Run controller for the 512-channel channelizer.
// Arms on a software start edge and runs frame-aligned from the next sync.
module chan_512_start_ctrl #(
  parameter int NCHAN     = 512,
  parameter int CHAN_BITS = 9
) (
  input  logic                 user_clk,
  input  logic                 user_rst_n,
  input  logic [31:0]          ctrl_word,
  input  logic                 sync_in,
  output logic                 run,
  output logic [CHAN_BITS-1:0] chan_idx,
  output logic                 frame_start,
  output logic [31:0]          frame_cnt,
  output logic [31:0]          status_word
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CHAN_BITS-1:0] LAST =
    CHAN_BITS'(NCHAN - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_start_q;
  logic                 r_stop_q;
  logic [CHAN_BITS-1:0] r_chan_idx;
  logic [CHAN_BITS-1:0] w_chan_nxt;
  logic [31:0]          r_frame_cnt;
  logic [31:0]          w_cnt_nxt;
  logic                 r_sync_err;
  logic                 w_err_nxt;
  logic                 r_run;
  logic                 r_frame_start;
  logic [31:0]          r_status;

  logic                 w_start_rise;
  logic                 w_stop_rise;
  logic                 w_single;
  logic [15:0]          w_nframes;
  logic [16:0]          w_target;
  logic                 w_last;
  logic                 w_misalign;
  logic [31:0]          w_cnt_inc;
  logic                 w_complete;
  logic                 w_unused_ok;

  assign w_start_rise = ctrl_word[0] & ~r_start_q;
  assign w_stop_rise  = ctrl_word[1] & ~r_stop_q;
  assign w_single     = ctrl_word[2];
  assign w_nframes    = ctrl_word[31:16];
  assign w_unused_ok  = ^ctrl_word[15:3];

  // nframes of zero stands for a full 65536-frame run
  assign w_target   = (w_nframes == 16'd0) ? 17'h10000
                                           : {1'b0, w_nframes};
  assign w_last     = (r_chan_idx == LAST);
  assign w_misalign = sync_in & ~w_last;
  assign w_cnt_inc  = r_frame_cnt + 32'd1;
  assign w_complete = w_single &
                      (w_cnt_inc == {15'd0, w_target});

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_start_q <= 1'b1;
      r_stop_q  <= 1'b1;
    end else begin
      r_start_q <= ctrl_word[0];
      r_stop_q  <= ctrl_word[1];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_chan_nxt  = r_chan_idx;
    w_cnt_nxt   = r_frame_cnt;
    w_err_nxt   = r_sync_err;
    if (w_stop_rise) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_rise) begin
            w_state_nxt = S_ARMED;
            w_cnt_nxt   = '0;
            w_err_nxt   = 1'b0;
          end
        end
        S_ARMED: begin
          if (sync_in) begin
            w_state_nxt = S_RUN;
            w_chan_nxt  = '0;
          end
        end
        S_RUN: begin
          if (w_misalign) begin
            // realign without counting a frame
            w_chan_nxt = '0;
            w_err_nxt  = 1'b1;
          end else begin
            w_chan_nxt = r_chan_idx + CHAN_BITS'(1);
            if (w_last) begin
              w_cnt_nxt = w_cnt_inc;
              if (w_complete) begin
                w_state_nxt = S_DONE;
              end
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_state       <= S_IDLE;
      r_chan_idx    <= '0;
      r_frame_cnt   <= '0;
      r_sync_err    <= 1'b0;
      r_run         <= 1'b0;
      r_frame_start <= 1'b0;
      r_status      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_chan_idx    <= w_chan_nxt;
      r_frame_cnt   <= w_cnt_nxt;
      r_sync_err    <= w_err_nxt;
      r_run         <= (w_state_nxt == S_RUN);
      r_frame_start <= (w_state_nxt == S_RUN) &&
                       (w_chan_nxt == '0);
      r_status      <= {w_cnt_nxt[15:0], 13'd0,
                        w_err_nxt, w_state_nxt};
    end
  end

  assign run         = r_run;
  assign chan_idx    = r_chan_idx;
  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;
  assign status_word = r_status;

endmodule
